mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
Iterative multiply/divide sequencer for the RV32M extension, sitting in the Execute stage beside the integer ALU. It accepts one operation per request and runs a shift-add multiply or restoring-divide loop over WIDTH cycles. It holds the pipeline stalled through its Busy output and returns a registered result with a one-cycle Valid pulse.

Parameters:
WIDTH, 32, operand and result width. The iteration count equals WIDTH. The internal counter is clog2(WIDTH)+1 bits.

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
StartE  input  1  request; sampled only in IDLE
FunctE  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
A  input  WIDTH  rs1 operand (dividend / multiplicand)
B  input  WIDTH  rs2 operand (divisor / multiplier)
FlushE  input  1  abort the current operation; no result is produced
BusyE  output  1  stall request to the hazard unit
ValidM  output  1  one-cycle pulse; ResultM is valid in this cycle
ResultM  output  WIDTH  registered result

Behaviour:
- Reset (asynchronous, RST=1):
  - state = IDLE; counter, accumulators and operand registers = 0.
  - ValidM = 0, ResultM = 0, BusyE = 0.
- States: IDLE, CALC, DONE.
- BusyE = (state != IDLE). It is combinational from registered state.
- IDLE:
  - On an edge with StartE=1 and FlushE=0, latch FunctE and absolute operand values.
  - Operand signedness per op: MULH, DIV and REM treat both operands as signed. MULHSU treats A as signed and B as unsigned. MUL, MULHU, DIVU and REMU treat both as unsigned.
  - Latch the negate-result flags:
    - Multiply: sign(A) xor sign(B).
    - Quotient: sign(A) xor sign(B).
    - Remainder: sign(A).
  - Go to CALC with count=0. If a special case applies, go straight to DONE instead.
- Special cases (decided at start; go directly to DONE):
  - Divide by zero (B=0): DIV/DIVU give all ones. REM/REMU give A.
  - Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): DIV gives 0x80000000. REM gives 0.
- CALC, one iteration per cycle, count increments each cycle:
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper half of the 2*WIDTH product using a WIDTH+1-bit carry. Then shift the product right by 1.
  - Divide (restoring): shift {rem, quo} left by 1, then trial = rem - divisor. If no borrow, rem = trial and quo LSB = 1.
  - After the iteration with count = WIDTH-1, go to DONE.
- DONE (exactly one cycle):
  - ValidM = 1. ResultM is registered on entry to DONE.
  - Result selection:
    - MUL: low WIDTH bits of the product.
    - MULH/MULHSU/MULHU: high WIDTH bits.
    - DIV/DIVU: quotient. REM/REMU: remainder.
  - Two's-complement negation (of the full 2*WIDTH product for multiply) is applied when the latched flag is set.
  - Next state is IDLE. ResultM holds its value until the next DONE. ValidM returns to 0.
- Latency:
  - Start sampled at edge 0, CALC in cycles 1..WIDTH, DONE in cycle WIDTH+1 (33 cycles for WIDTH=32).
  - Special case: DONE in cycle 1.
- StartE in CALC or DONE is ignored. The hazard unit must hold the instruction in E until ValidM.
- FlushE in any state: next state is IDLE, ValidM = 0 next cycle, ResultM is unchanged.
- FlushE and StartE together in IDLE: flush wins and the request is dropped.
- Back-to-back: StartE is accepted on the first IDLE cycle after DONE. It is not accepted during DONE.
- RST asserted mid-CALC: immediate return to IDLE with all outputs zero. No Valid pulse.
- FunctE/A/B changes after the start edge have no effect.

Test Plan:
- MUL 7 x 6, then MULHU 0xFFFFFFFF x 0xFFFFFFFF -> BusyE high for 33 cycles each. ValidM pulses at cycle 33 with 42, then 0xFFFFFFFE.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF(-1) x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. All three have ValidM at cycle 1 and BusyE high for one cycle.
- FlushE at CALC cycle 10 -> IDLE next cycle, no ValidM, ResultM keeps its prior value. StartE with FlushE in IDLE -> no operation starts.
- RST pulse mid-CALC, then StartE during CALC of a new op -> outputs zero after reset. The second StartE is ignored. Only one ValidM pulse per accepted op.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one iteration per cycle, with a stall output and a one-cycle result-valid pulse.
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             StartE,
  input  logic [2:0]       FunctE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             FlushE,
  output logic             BusyE,
  output logic             ValidM,
  output logic [WIDTH-1:0] ResultM
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [2:0]           funct_q, funct_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 valid_q, valid_d;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic               a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b, special_res;
  logic               is_special;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH-1:0] mul_next, div_next, acc_step, prod_fix;
  logic [WIDTH-1:0]   div_sel, calc_res;

  assign a_signed = (FunctE == 3'b001) || (FunctE == 3'b010) ||
                    (FunctE == 3'b100) || (FunctE == 3'b110);
  assign b_signed = (FunctE == 3'b001) || (FunctE == 3'b100) || (FunctE == 3'b110);
  assign a_neg    = a_signed & A[WIDTH-1];
  assign b_neg    = b_signed & B[WIDTH-1];
  assign abs_a    = a_neg ? neg_w(A) : A;
  assign abs_b    = b_neg ? neg_w(B) : B;

  // Divide-by-zero and signed overflow are resolved at start without iterating.
  always_comb begin
    is_special  = 1'b0;
    special_res = '0;
    if (FunctE[2] && (B == '0)) begin
      is_special  = 1'b1;
      special_res = FunctE[1] ? A : '1;
    end else if (FunctE[2] && !FunctE[0] && (A == MIN_NEG) && (B == '1)) begin
      is_special  = 1'b1;
      special_res = FunctE[1] ? '0 : MIN_NEG;
    end else begin
      is_special  = 1'b0;
      special_res = '0;
    end
  end

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign trial    = {1'b0, rem_sh} - {2'b00, opnd_q};
  assign div_next = trial[WIDTH+1] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign acc_step = funct_q[2] ? div_next : mul_next;
  assign prod_fix = neg_q ? neg_2w(acc_step) : acc_step;
  assign div_sel  = funct_q[1] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];

  // Final result is taken from the last iteration's value so it registers on entry to DONE.
  always_comb begin
    calc_res = '0;
    case (funct_q)
      3'b000:                 calc_res = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: calc_res = prod_fix[2*WIDTH-1:WIDTH];
      default:                calc_res = neg_q ? neg_w(div_sel) : div_sel;
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    funct_d  = funct_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (FlushE) begin
          state_d = IDLE;
        end else if (StartE) begin
          funct_d = FunctE;
          neg_d   = (FunctE[2] && FunctE[1]) ? a_neg : (a_neg ^ b_neg);
          count_d = '0;
          opnd_d  = FunctE[2] ? abs_b : abs_a;
          acc_d   = {{WIDTH{1'b0}}, (FunctE[2] ? abs_a : abs_b)};
          if (is_special) begin
            state_d  = DONE;
            result_d = special_res;
            valid_d  = 1'b1;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (FlushE) begin
          state_d = IDLE;
        end else begin
          acc_d   = acc_step;
          count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
          if (count_q == LAST_CNT) begin
            state_d  = DONE;
            result_d = calc_res;
            valid_d  = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      funct_q  <= 3'b000;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct_q  <= funct_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign BusyE   = (state_q != IDLE);
  assign ValidM  = valid_q;
  assign ResultM = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed scoreboard bench for mdu_sequencer: expected results are queued at
// request time and popped when ValidM pulses.
module tb_mdu_sequencer;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST, StartE, FlushE;
  logic [2:0]   FunctE;
  logic [W-1:0] A, B;
  logic         BusyE, ValidM;
  logic [W-1:0] ResultM;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res;

  mdu_sequencer #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .StartE(StartE), .FunctE(FunctE), .A(A), .B(B),
    .FlushE(FlushE), .BusyE(BusyE), .ValidM(ValidM), .ResultM(ResultM)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] expv,
                        input int exp_lat, input int extra_cyc);
    int           busy_cnt = 0;
    int           lat = -1;
    logic         seen = 1'b0;
    logic [W-1:0] popped;
    @(negedge CLK);
    StartE = 1'b1; FunctE = f; A = a; B = b;
    exp_q.push_back(expv);
    @(negedge CLK);
    StartE = 1'b0; FunctE = ~f; A = ~a; B = b ^ 32'h0000_00F0;
    for (int c = 1; c <= 100; c++) begin
      if (c == extra_cyc) begin
        StartE = 1'b1; FunctE = 3'b100; A = 32'd77; B = 32'd0;
      end else begin
        StartE = 1'b0;
      end
      if (BusyE) busy_cnt++;
      if (ValidM) begin
        seen = 1'b1;
        lat  = c;
        break;
      end
      @(negedge CLK);
    end
    StartE = 1'b0;
    check({tag, "_valid_seen"}, {31'd0, seen}, 32'd1);
    popped = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_result"}, ResultM, popped);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    @(negedge CLK);
    check({tag, "_valid_drop"}, {31'd0, ValidM}, 32'd0);
    check({tag, "_busy_drop"}, {31'd0, BusyE}, 32'd0);
    check({tag, "_result_hold"}, ResultM, popped);
    last_res = popped;
  endtask

  task automatic count_valids(input string tag, input int cycles, input int expn);
    int n = 0;
    for (int c = 0; c < cycles; c++) begin
      if (ValidM) n++;
      @(negedge CLK);
    end
    check(tag, n, expn);
  endtask

  initial begin
    RST = 1'b1; StartE = 1'b0; FlushE = 1'b0; FunctE = 3'b000; A = '0; B = '0;
    last_res = '0;
    #12;
    check("reset_busy", {31'd0, BusyE}, 32'd0);
    check("reset_valid", {31'd0, ValidM}, 32'd0);
    check("reset_result", ResultM, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    run_op("mul_7x6",      3'b000, 32'd7,         32'd6,         32'd42,        33, 0);
    run_op("mulhu_max",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op("mulh_min",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("mulhsu_m1x2",  3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op("mul_neg",      3'b000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 33, 0);
    run_op("div_m7_2",     3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0);
    run_op("rem_m7_2",     3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op("divu_100_7",   3'b101, 32'd100,       32'd7,         32'd14,        33, 0);
    run_op("remu_100_7",   3'b111, 32'd100,       32'd7,         32'd2,         33, 0);
    run_op("divu_by0",     3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0);
    run_op("rem_by0",      3'b110, 32'd5,         32'd0,         32'd5,         1,  0);
    run_op("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
    run_op("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  0);

    // Flush in the middle of a divide: no result, ResultM unchanged.
    @(negedge CLK);
    StartE = 1'b1; FunctE = 3'b101; A = 32'd1000; B = 32'd3;
    @(negedge CLK);
    StartE = 1'b0;
    repeat (9) @(negedge CLK);
    check("flush_busy_before", {31'd0, BusyE}, 32'd1);
    FlushE = 1'b1;
    @(negedge CLK);
    FlushE = 1'b0;
    check("flush_busy_after", {31'd0, BusyE}, 32'd0);
    check("flush_valid_after", {31'd0, ValidM}, 32'd0);
    check("flush_result_hold", ResultM, last_res);
    count_valids("flush_no_valid", 40, 0);

    // Start together with flush in IDLE is dropped.
    StartE = 1'b1; FlushE = 1'b1; FunctE = 3'b000; A = 32'd3; B = 32'd3;
    @(negedge CLK);
    StartE = 1'b0; FlushE = 1'b0;
    check("startflush_busy", {31'd0, BusyE}, 32'd0);
    count_valids("startflush_no_valid", 40, 0);

    // Reset mid-calculation clears all outputs immediately.
    StartE = 1'b1; FunctE = 3'b000; A = 32'd9; B = 32'd9;
    @(negedge CLK);
    StartE = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, BusyE}, 32'd0);
    check("rst_mid_valid", {31'd0, ValidM}, 32'd0);
    check("rst_mid_result", ResultM, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    count_valids("rst_no_valid", 40, 0);

    // A second start during CALC is ignored; exactly one pulse results.
    run_op("mul_after_rst", 3'b000, 32'd3, 32'd5, 32'd15, 33, 5);
    count_valids("ignored_start_no_valid", 40, 0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
